// File: rtl/i2s_pkg.sv
// i2s_pkg: shared defaults and the stereo sample bundle for the I2S
// transmit path.
package i2s_pkg;

   localparam int I2S_WIDTH = 16;
   localparam int I2S_SLOT  = 32;

   typedef struct packed {
      logic [I2S_WIDTH-1:0] left;
      logic [I2S_WIDTH-1:0] right;
   } sample_pair_t;

endpackage

// File: rtl/i2s_tx_bck_edge_det.sv
// bck_edge_det: samples the bit clock and master clock levels in the clk
// domain and flags bit-clock edges.
module bck_edge_det (
   input  logic clk,
   input  logic reset,
   input  logic bck,
   input  logic sck,
   output logic bck_q,
   output logic fall,
   output logic rise,
   output logic mclk
);

   always_ff @(posedge clk) begin
      if (reset) begin
         bck_q <= 1'b0;
         mclk  <= 1'b0;
      end else begin
         bck_q <= bck;
         mclk  <= sck;
      end
   end

   assign fall = bck_q & ~bck;
   assign rise = ~bck_q & bck;

endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: I2S serial transmitter with a one-entry sample holding buffer.
// Define I2S_UNDERRUN_CNT_EN to add the saturating underrun_cnt port.
module i2s_tx
   import i2s_pkg::*;
#(
   parameter int WIDTH = I2S_WIDTH,
   parameter int SLOT  = I2S_SLOT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             bck,
   input  logic             sck,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [WIDTH-1:0] s_left,
   input  logic [WIDTH-1:0] s_right,
   output logic             mclk,
   output logic             sclk,
   output logic             lrck,
   output logic             sdata,
   output logic             underrun
`ifdef I2S_UNDERRUN_CNT_EN
   ,
   output logic [15:0]      underrun_cnt
`endif
);

   localparam int CW = $clog2(2 * SLOT);
   localparam int IW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST   = CW'(2 * SLOT - 1);
   localparam logic [CW-1:0] SLOT_C = CW'(SLOT);
   localparam logic [CW-1:0] W_C    = CW'(WIDTH);

   logic            bck_q;
   logic            fall;
   logic            unused_rise;
   logic [CW-1:0]   bit_cnt;
   logic            hold_full;
   sample_pair_t    hold;
   sample_pair_t    frame;

   logic [CW-1:0]   cnt_nxt;
   logic [CW-1:0]   p_nxt;
   logic            lr_nxt;
   logic            load;
   logic            ur_set;
   logic [IW-1:0]   idx;
   logic [WIDTH-1:0] chan;
   logic            bit_nxt;

   bck_edge_det u_edge (
      .clk   (clk),
      .reset (reset),
      .bck   (bck),
      .sck   (sck),
      .bck_q (bck_q),
      .fall  (fall),
      .rise  (unused_rise),
      .mclk  (mclk)
   );

   assign sclk    = bck_q;
   assign s_ready = ~hold_full & ~reset;

   always_comb begin
      cnt_nxt = '0;
      p_nxt   = '0;
      lr_nxt  = 1'b0;
      chan    = '0;
      idx     = '0;
      bit_nxt = 1'b0;
      if (bit_cnt != LAST)
         cnt_nxt = bit_cnt + 1'b1;
      lr_nxt = (cnt_nxt >= SLOT_C);
      p_nxt  = lr_nxt ? (cnt_nxt - SLOT_C) : cnt_nxt;
      chan   = lr_nxt ? frame.right : frame.left;
      idx    = IW'(W_C - p_nxt);
      // One-bit I2S delay: slot position 0 is always a zero bit.
      if ((p_nxt != '0) && (p_nxt <= W_C))
         bit_nxt = chan[idx];
   end

   assign load   = fall & (bit_cnt == LAST);
   assign ur_set = load & ~hold_full;

   always_ff @(posedge clk) begin
      if (reset) begin
         bit_cnt   <= LAST;
         lrck      <= 1'b1;
         sdata     <= 1'b0;
         underrun  <= 1'b0;
         hold_full <= 1'b0;
         hold      <= '0;
         frame     <= '0;
      end else begin
         underrun <= ur_set;
         if (s_valid && s_ready) begin
            hold      <= '{left: s_left, right: s_right};
            hold_full <= 1'b1;
         end
         if (fall) begin
            bit_cnt <= cnt_nxt;
            lrck    <= lr_nxt;
            sdata   <= bit_nxt;
         end
         // A pair accepted in the load cycle waits for the next frame.
         if (load) begin
            if (hold_full) begin
               frame     <= hold;
               hold_full <= 1'b0;
            end else begin
               frame <= '0;
            end
         end
      end
   end

`ifdef I2S_UNDERRUN_CNT_EN
   always_ff @(posedge clk) begin
      if (reset)
         underrun_cnt <= '0;
      else if (ur_set && (underrun_cnt != 16'hFFFF))
         underrun_cnt <= underrun_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: directed and randomized bench for i2s_tx against a
// fall-count based reference model.
module tb_i2s_tx;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        bck = 1'b0;
   logic        sck = 1'b0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [15:0] s_left = '0;
   logic [15:0] s_right = '0;
   logic        mclk, sclk, lrck, sdata, underrun;
`ifdef I2S_UNDERRUN_CNT_EN
   logic [15:0] underrun_cnt;
`endif

   i2s_tx dut (
      .clk      (clk),
      .reset    (reset),
      .bck      (bck),
      .sck      (sck),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .s_left   (s_left),
      .s_right  (s_right),
      .mclk     (mclk),
      .sclk     (sclk),
      .lrck     (lrck),
      .sdata    (sdata),
      .underrun (underrun)
`ifdef I2S_UNDERRUN_CNT_EN
      ,
      .underrun_cnt (underrun_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;
   int ur_seen = 0;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_chk++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
   endtask

   // Reference model: frame position is derived from the number of bck
   // falls since reset; every 64th fall (starting with the first) begins
   // a new frame and takes the held pair if there is one.
   int          m_falls = 0;
   bit          m_full = 0;
   logic [15:0] m_hl = '0, m_hr = '0, m_fl = '0, m_fr = '0;
   bit          m_bckq = 0, m_sck = 0, m_ur = 0;
   logic [15:0] m_urc = '0;

   always @(posedge clk) begin
      bit f, acc;
      if (reset) begin
         m_falls = 0; m_full = 0; m_fl = '0; m_fr = '0;
         m_bckq = 0; m_sck = 0; m_ur = 0; m_urc = '0;
      end else begin
         f = m_bckq && !bck;
         acc = s_valid && !m_full;
         m_ur = 0;
         if (f) begin
            m_falls++;
            if ((m_falls - 1) % 64 == 0) begin
               if (m_full) begin
                  m_fl = m_hl; m_fr = m_hr; m_full = 0;
               end else begin
                  m_fl = '0; m_fr = '0; m_ur = 1;
                  if (m_urc != 16'hFFFF) m_urc++;
               end
            end
         end
         if (acc) begin
            m_hl = s_left; m_hr = s_right; m_full = 1;
         end
         m_bckq = bck;
         m_sck = sck;
      end
   end

   always @(negedge clk) begin
      int c, p;
      logic [15:0] s;
      logic e_lr, e_sd;
      if (chk_en) begin
         e_lr = 1'b1;
         e_sd = 1'b0;
         if (m_falls > 0) begin
            c = (m_falls - 1) % 64;
            p = c % 32;
            e_lr = (c >= 32);
            s = e_lr ? m_fr : m_fl;
            if (p >= 1 && p <= 16) e_sd = s[16 - p];
         end
         check("lrck", 64'(lrck), 64'(e_lr));
         check("sdata", 64'(sdata), 64'(e_sd));
         check("sclk", 64'(sclk), 64'(m_bckq));
         check("mclk", 64'(mclk), 64'(m_sck));
         check("underrun", 64'(underrun), 64'(m_ur));
         check("s_ready", 64'(s_ready), 64'(!m_full && !reset));
`ifdef I2S_UNDERRUN_CNT_EN
         check("underrun_cnt", 64'(underrun_cnt), 64'(m_urc));
`endif
         if (underrun) ur_seen++;
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1 sck = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic push(input logic [15:0] l, input logic [15:0] r,
                       input int maxc, output int waited);
      @(posedge clk);
      #1 s_valid = 1'b1; s_left = l; s_right = r;
      waited = 0;
      @(negedge clk);
      while (!s_ready && waited < maxc) begin
         @(negedge clk);
         waited++;
      end
      check("push_ready", 64'(s_ready), 64'(1));
      @(posedge clk);
      #1 s_valid = 1'b0;
   endtask

   // One bck period of 8 clk: 4 high, 4 low; samples the outputs the
   // cycle after the fall takes effect.
   task automatic bit_time(output logic l, output logic d);
      @(posedge clk);
      #1 bck = 1'b1;
      repeat (4) @(posedge clk);
      #1 bck = 1'b0;
      @(posedge clk);
      @(negedge clk);
      l = lrck;
      d = sdata;
      repeat (2) @(posedge clk);
   endtask

   task automatic do_reset(input int n);
      @(posedge clk);
      #1 reset = 1'b1; s_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   initial begin
      logic l, d;
      logic [31:0] cl, cr, ll, lr;
      logic [63:0] lw;
      logic sd_or;
      int w, thr;

      // Reset
      @(posedge clk);
      #1 chk_en = 1'b1;
      @(negedge clk);
      check("rst_ready_low", 64'(s_ready), 64'(0));
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_lrck", 64'(lrck), 64'(1));
      check("rst_sdata", 64'(sdata), 64'(0));
      check("rst_sclk", 64'(sclk), 64'(0));
      check("rst_ready", 64'(s_ready), 64'(1));
      check("rst_underrun", 64'(underrun), 64'(0));

      // Single frame
      ur_seen = 0;
      push(16'hA5F0, 16'h0F0F, 10, w);
      for (int i = 0; i < 64; i++) begin
         bit_time(l, d);
         if (i < 32) begin
            cl[31-i] = d; ll[31-i] = l;
         end else begin
            cr[63-i] = d; lr[63-i] = l;
         end
      end
      check("sf_left_bits", 64'(cl), 64'(32'h52F8_0000));
      check("sf_right_bits", 64'(cr), 64'(32'h0787_8000));
      check("sf_left_lrck", 64'(ll), 64'(32'h0));
      check("sf_right_lrck", 64'(lr), 64'(32'hFFFF_FFFF));
      check("sf_no_underrun", 64'(ur_seen), 64'(0));

      // Backpressure
      do_reset(2);
      ur_seen = 0;
      w = 0;
      fork
         begin
            int wa;
            push(16'hC3C3, 16'h5555, 10, wa);
            push(16'h1234, 16'h8001, 100, w);
         end
         begin
            repeat (6) @(posedge clk);
            for (int i = 0; i < 128; i++) begin
               bit_time(l, d);
               if (i >= 64 && i < 96) cl[95-i] = d;
            end
         end
      join
      check("bp_b_waited", 64'(w >= 3), 64'(1));
      check("bp_b_left_bits", 64'(cl), 64'(32'h091A_0000));
      check("bp_no_underrun", 64'(ur_seen), 64'(0));

      // Underrun
      ur_seen = 0;
      sd_or = 1'b0;
      for (int i = 0; i < 64; i++) begin
         bit_time(l, d);
         sd_or |= d;
         lw[63-i] = l;
      end
      check("ur_pulses", 64'(ur_seen), 64'(1));
      check("ur_sdata_zero", 64'(sd_or), 64'(0));
      check("ur_lrck_toggle", lw, 64'h0000_0000_FFFF_FFFF);
`ifdef I2S_UNDERRUN_CNT_EN
      check("ur_cnt_one", 64'(underrun_cnt), 64'(1));
`endif

      // Reset mid-frame
      do_reset(2);
      push(16'hDEAD, 16'hBEEF, 10, w);
      for (int i = 0; i < 21; i++) bit_time(l, d);
      push(16'hFFFF, 16'hFFFF, 10, w);
      @(negedge clk);
      check("mf_held", 64'(s_ready), 64'(0));
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("mf_rst_lrck", 64'(lrck), 64'(1));
      check("mf_rst_sdata", 64'(sdata), 64'(0));
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("mf_ready_after", 64'(s_ready), 64'(1));
      ur_seen = 0;
      bit_time(l, d);
      check("mf_first_lrck", 64'(l), 64'(0));
      check("mf_first_sdata", 64'(d), 64'(0));
      sd_or = 1'b0;
      for (int i = 0; i < 16; i++) begin
         bit_time(l, d);
         sd_or |= d;
      end
      check("mf_pair_dropped", 64'(sd_or), 64'(0));
      check("mf_underrun", 64'(ur_seen), 64'(1));

      // Static bck
      do_reset(2);
      bck = 1'b1;
      push(16'h7E7E, 16'h8181, 10, w);
      ur_seen = 0;
      repeat (200) @(posedge clk);
      @(negedge clk);
      check("st_lrck", 64'(lrck), 64'(1));
      check("st_sdata", 64'(sdata), 64'(0));
      check("st_ready", 64'(s_ready), 64'(0));
      check("st_underrun", 64'(ur_seen), 64'(0));

      // Randomized traffic
      do_reset(2);
      for (int i = 0; i < 6000; i++) begin
         @(posedge clk);
         thr = (i < 3000) ? 600 : 2;
         #1;
         if ($urandom_range(0, 2) == 0) bck = ~bck;
         s_valid = ($urandom_range(0, 999) < thr);
         s_left = 16'($urandom);
         s_right = 16'($urandom);
         reset = ($urandom_range(0, 1499) == 0);
      end
      @(posedge clk);
      #1 reset = 1'b0; s_valid = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
